// File: rtl/queue_enq_arbiter_pkg.sv
// Shared types and helpers for the queue enqueue arbiter slice.
// The FSM state enum and index-width helper live here so the top and the picker agree.
package queue_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/queue_enq_arbiter_if.sv
// Producer/queue handshake bundle for queue_enq_arbiter.
// master = producers plus queue status, slave = the arbiter.
interface queue_enq_arbiter_if
  import queue_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) ();

  localparam int GW = idx_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic                   q_full;
  logic                   q_enqueue;
  logic [WIDTH-1:0]       q_data;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  modport master (
    output req_valid, req_data, req_last, q_full,
    input  req_ready, q_enqueue, q_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, q_full,
    output req_ready, q_enqueue, q_data, grant_id, busy
  );

endinterface

// File: rtl/queue_enq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Works for non-power-of-2 N because the rotation wraps explicitly at N.
module rr_pick
  import queue_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return IW'(s);
  endfunction

  // Scan requests starting at ptr; the first hit wins.
  always_comb begin
    winner    = {IW{1'b0}};
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_valid && req[rot_idx(ptr, i)]) begin
        any_valid = 1'b1;
        winner    = rot_idx(ptr, i);
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/queue_enq_arbiter.sv
// Round-robin burst arbiter sharing one queue enqueue port among N_REQ producers.
// One idle arbitration cycle precedes every burst; q_full stalls the burst in place.
module queue_enq_arbiter
  import queue_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  queue_enq_arbiter_if.slave  bus
);

  localparam int GW = idx_w(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_r;
  logic [GW-1:0] rr_ptr_r;
  logic [GW-1:0] grant_id_r;
  logic [CW-1:0] beat_cnt_r;
  logic          busy_r;

  logic [GW-1:0] winner_s;
  logic          any_valid_s;
  logic          burst_s;
  logic          open_s;
  logic          xfer_s;
  logic          end_s;

  rr_pick #(.N(N_REQ), .IW(GW)) u_rr_pick (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Handshake decode; rst gates ready/enqueue so nothing is accepted in a reset cycle.
  always_comb begin
    burst_s       = (state_r == ARB_BURST);
    open_s        = burst_s && !bus.q_full && !rst;
    xfer_s        = open_s && bus.req_valid[grant_id_r];
    end_s         = xfer_s && (bus.req_last[grant_id_r] ||
                               (beat_cnt_r + CW'(1) == CW'(MAX_BURST)));
    bus.req_ready = {N_REQ{1'b0}};
    if (open_s) begin
      bus.req_ready[grant_id_r] = 1'b1;
    end else begin
      bus.req_ready = {N_REQ{1'b0}};
    end
    bus.q_enqueue = xfer_s;
    if (burst_s) begin
      bus.q_data = bus.req_data[grant_id_r*WIDTH +: WIDTH];
    end else begin
      bus.q_data = {WIDTH{1'b0}};
    end
  end

  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;

  // Arbitration FSM, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= {GW{1'b0}};
      grant_id_r <= {GW{1'b0}};
      beat_cnt_r <= {CW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_valid_s) begin
            grant_id_r <= winner_s;
            beat_cnt_r <= {CW{1'b0}};
            state_r    <= ARB_BURST;
            busy_r     <= 1'b1;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        ARB_BURST: begin
          if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CW'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
          if (end_s) begin
            state_r  <= ARB_IDLE;
            busy_r   <= 1'b0;
            rr_ptr_r <= (grant_id_r == GW'(N_REQ - 1)) ? {GW{1'b0}} : grant_id_r + GW'(1);
          end else begin
            busy_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed self-checking bench for queue_enq_arbiter (WIDTH=8, N_REQ=4, MAX_BURST=4).
module tb_queue_enq_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   beats;
  int   cycles;

  queue_enq_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus ();

  queue_enq_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[k]         = v;
    bus.req_data[k*8 +: 8]   = d;
    bus.req_last[k]          = l;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    beats  = 0;
    cycles = 0;
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_data  = 32'h0000_0000;
    bus.req_last  = 4'b0000;
    bus.q_full    = 1'b0;
    tick();
    chk("rst_enq", 32'(bus.q_enqueue), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    chk("rst_qdata", 32'(bus.q_data), 32'd0);
    chk("rst_rrptr", 32'(dut.rr_ptr_r), 32'd0);

    // Fairness: everybody valid, no last -> 0,1,2,3,0 with 4 beats each
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'(8'hA0 + k), 1'b0);
    for (int gi = 0; gi < 5; gi++) begin
      #1;
      chk("fair_idle_busy", 32'(bus.busy), 32'd0);
      chk("fair_idle_enq", 32'(bus.q_enqueue), 32'd0);
      if (gi != 0) cycles++;
      tick();
      for (int b = 0; b < 4; b++) begin
        #1;
        chk("fair_gid", 32'(bus.grant_id), 32'(gi % 4));
        chk("fair_enq", 32'(bus.q_enqueue), 32'd1);
        chk("fair_data", 32'(bus.q_data), 32'(8'hA0 + (gi % 4)));
        beats += int'(bus.q_enqueue);
        cycles++;
        tick();
      end
    end
    bus.req_valid = 4'b0000;
    #1;
    chk("fair_beats", 32'(beats), 32'd20);
    chk("fair_cycles", 32'(cycles), 32'd24);
    chk("fair_end_busy", 32'(bus.busy), 32'd0);
    chk("fair_rrptr", 32'(dut.rr_ptr_r), 32'd1);

    // Single burst from requester 2: 0x11, 0x22, 0x33(last)
    set_req(2, 1'b1, 8'h11, 1'b0);
    #1;
    chk("sb_idle_enq", 32'(bus.q_enqueue), 32'd0);
    tick();
    chk("sb_gid", 32'(bus.grant_id), 32'd2);
    chk("sb_busy", 32'(bus.busy), 32'd1);
    chk("sb_ready", 32'(bus.req_ready), 32'b0100);
    chk("sb_enq1", 32'(bus.q_enqueue), 32'd1);
    chk("sb_d1", 32'(bus.q_data), 32'h11);
    tick();
    set_req(2, 1'b1, 8'h22, 1'b0);
    #1;
    chk("sb_enq2", 32'(bus.q_enqueue), 32'd1);
    chk("sb_d2", 32'(bus.q_data), 32'h22);
    tick();
    set_req(2, 1'b1, 8'h33, 1'b1);
    #1;
    chk("sb_enq3", 32'(bus.q_enqueue), 32'd1);
    chk("sb_d3", 32'(bus.q_data), 32'h33);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    #1;
    chk("sb_end_busy", 32'(bus.busy), 32'd0);
    chk("sb_end_enq", 32'(bus.q_enqueue), 32'd0);
    chk("sb_rrptr", 32'(dut.rr_ptr_r), 32'd3);

    // Early last from requester 3: single beat, pointer wraps to 0
    set_req(3, 1'b1, 8'hA5, 1'b1);
    tick();
    chk("el_gid", 32'(bus.grant_id), 32'd3);
    chk("el_enq", 32'(bus.q_enqueue), 32'd1);
    chk("el_data", 32'(bus.q_data), 32'hA5);
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);
    #1;
    chk("el_busy", 32'(bus.busy), 32'd0);
    chk("el_enq_after", 32'(bus.q_enqueue), 32'd0);
    chk("el_rrptr_wrap", 32'(dut.rr_ptr_r), 32'd0);

    // Wrap/priority: 0 and 2 valid -> 0 first, then 2
    set_req(0, 1'b1, 8'h01, 1'b1);
    set_req(2, 1'b1, 8'h02, 1'b1);
    tick();
    chk("wr_gid0", 32'(bus.grant_id), 32'd0);
    chk("wr_data0", 32'(bus.q_data), 32'h01);
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("wr_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("wr_gid2", 32'(bus.grant_id), 32'd2);
    chk("wr_enq2", 32'(bus.q_enqueue), 32'd1);
    chk("wr_data2", 32'(bus.q_data), 32'h02);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    #1;
    chk("wr_rrptr", 32'(dut.rr_ptr_r), 32'd3);

    // Back-pressure: requester 3, 4 beats, q_full for 2 cycles after beat 2
    set_req(3, 1'b1, 8'h31, 1'b0);
    tick();
    chk("bp_d1", 32'(bus.q_data), 32'h31);
    chk("bp_enq1", 32'(bus.q_enqueue), 32'd1);
    tick();
    set_req(3, 1'b1, 8'h32, 1'b0);
    #1;
    chk("bp_d2", 32'(bus.q_data), 32'h32);
    tick();
    set_req(3, 1'b1, 8'h33, 1'b0);
    bus.q_full = 1'b1;
    #1;
    chk("bp_full_enq_a", 32'(bus.q_enqueue), 32'd0);
    chk("bp_full_ready_a", 32'(bus.req_ready), 32'd0);
    chk("bp_full_cnt_a", 32'(dut.beat_cnt_r), 32'd2);
    tick();
    chk("bp_full_enq_b", 32'(bus.q_enqueue), 32'd0);
    chk("bp_full_cnt_b", 32'(dut.beat_cnt_r), 32'd2);
    chk("bp_full_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.q_full = 1'b0;
    #1;
    chk("bp_enq3", 32'(bus.q_enqueue), 32'd1);
    chk("bp_d3", 32'(bus.q_data), 32'h33);
    chk("bp_ready3", 32'(bus.req_ready), 32'b1000);
    tick();
    set_req(3, 1'b1, 8'h34, 1'b0);
    #1;
    chk("bp_d4", 32'(bus.q_data), 32'h34);
    chk("bp_cnt3", 32'(dut.beat_cnt_r), 32'd3);
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);
    #1;
    chk("bp_end_busy", 32'(bus.busy), 32'd0);
    chk("bp_rrptr", 32'(dut.rr_ptr_r), 32'd0);

    // Reset mid-burst: requester 1 after 2 beats
    set_req(1, 1'b1, 8'h41, 1'b0);
    tick();
    chk("rm_gid", 32'(bus.grant_id), 32'd1);
    tick();
    set_req(1, 1'b1, 8'h42, 1'b0);
    tick();
    set_req(1, 1'b1, 8'h43, 1'b0);
    rst = 1'b1;
    #1;
    chk("rm_enq_in_rst", 32'(bus.q_enqueue), 32'd0);
    chk("rm_ready_in_rst", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 8'h05, 1'b0);
    #1;
    chk("rm_busy", 32'(bus.busy), 32'd0);
    chk("rm_gid_rst", 32'(bus.grant_id), 32'd0);
    chk("rm_rrptr", 32'(dut.rr_ptr_r), 32'd0);
    tick();
    chk("rm_win0", 32'(bus.grant_id), 32'd0);
    chk("rm_win0_busy", 32'(bus.busy), 32'd1);
    chk("rm_win0_data", 32'(bus.q_data), 32'h05);
    bus.req_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/queue_enq_arbiter.md
# queue_enq_arbiter

Round-robin, burst-capable arbiter that shares the single enqueue port of a parameterized queue between N_REQ producers. It sits directly in front of the queue. It accepts valid/ready bursts from each requester, forwards one beat per cycle to the queue's enqueue/data inputs, and honours the queue's full flag as back-pressure. Dequeue side and queue storage are outside this block.

## Interface
- WIDTH, 8, data width of one beat; must match the queue's WIDTH.
- N_REQ, 4, number of requesters; minimum 2.
- MAX_BURST, 4, maximum beats per grant; minimum 1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*WIDTH  flattened beats; requester k occupies bits [k*WIDTH +: WIDTH].
- req_last  in  N_REQ  per-requester end-of-burst marker, qualified by valid.
- req_ready  out  N_REQ  per-requester beat accept; one-hot or zero.
- q_full  in  1  queue full flag.
- q_enqueue  out  1  enqueue strobe to queue.
- q_data  out  WIDTH  data to queue.
- grant_id  out  $clog2(N_REQ)  index of current grant holder.
- busy  out  1  high while in ARB_BURST.

## Operation
- States: ARB_IDLE, ARB_BURST.
- ARB_IDLE: if any req_valid is set, pick the winner via round-robin starting at rr_ptr (first set bit at or above rr_ptr, wrapping). Register grant_id := winner, beat_cnt := 0, next state ARB_BURST. No transfer occurs in ARB_IDLE.
- ARB_BURST, with g = grant_id:
  - req_ready[g] = !q_full; all other ready bits 0.
  - q_enqueue = req_valid[g] && !q_full.
  - q_data = req_data[g] (combinational mux).
- Transfer: q_enqueue high at a rising edge. Each transfer increments beat_cnt.
- Burst end: a transfer with req_last[g]=1, or a transfer that makes beat_cnt == MAX_BURST. Next state is ARB_IDLE, and rr_ptr := (g+1) mod N_REQ.
- Requester stall: grant is held while req_valid[g]=0; no timeout.
- req_valid/req_data of non-granted requesters are ignored. Requesters must hold valid and data until ready.
- q_full high: no transfer; beat_cnt, grant_id and state hold.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
  - rr_ptr wraps at N_REQ-1 → 0, including for non-power-of-2 N_REQ.
- Reset values: state ARB_IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, busy 0, q_enqueue 0, req_ready 0, q_data 0 (muxed from requester 0 is acceptable only if q_enqueue is 0).
- Reset mid-burst:
  - While rst is high, q_enqueue and req_ready are forced to 0 combinationally, so no beat is lost or duplicated in the reset cycle.
  - The interrupted burst is abandoned.

## Timing
- Arbitration latency: req_valid rising in cycle t (state ARB_IDLE) → grant_id/busy valid from edge t+1 → first possible transfer at edge t+2.
- Throughput: one beat per cycle within a burst. One ARB_IDLE bubble cycle between consecutive bursts.
- q_full is sampled combinationally in the same cycle. The queue's full flag must already reflect the previous cycle's enqueue.
- busy equals (state == ARB_BURST), registered.

## Structure
- Package queue_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_BURST};
  - localparam helper function for index width (clog2 with minimum 1).
- Sub-module rr_pick #(N) holds the combinational round-robin picker: inputs req[N] and ptr; outputs winner index and any_valid. It is instantiated once.
- The top level holds the FSM, the counters and the data mux.

## Test plan
- Single burst: requester 2 only, beats 0x11, 0x22, 0x33 with last on 0x33, q_full=0 → grant_id=2 and busy=1 one cycle after valid; q_enqueue high for exactly 3 cycles with q_data 0x11, 0x22, 0x33; busy=0 next cycle; rr_ptr=3.
- Fairness: all 4 requesters continuously valid, no last, MAX_BURST=4 → grants 0,1,2,3,0 in order; each holds 4 beats; one idle cycle between grants; 20 beats in 24 cycles.
- Back-pressure: q_full high for 2 cycles after the 2nd beat of a 4-beat burst → req_ready[g] and q_enqueue low for those 2 cycles; beat_cnt holds at 2; burst completes with 4 beats total and no duplicates.
- Wrap/priority: after requester 3 finishes, requesters 0 and 2 are valid → requester 0 is granted; after 0 finishes, requester 2 is granted.
- Early last: MAX_BURST=4, req_last on first beat → exactly 1 beat transferred; state returns to ARB_IDLE.
- Reset mid-burst: rst high for 1 cycle after 2 beats of requester 1 → q_enqueue=0 during rst; then state ARB_IDLE, grant_id=0, rr_ptr=0; with requesters 0 and 1 valid, requester 0 wins.
